// File: rtl/ex_flow_ctrl.sv
// EX-stage flow controller: sequences branch/call/return PC updates, detects
// load-use hazards and drives stall/bubble/flush controls with a wait timeout.
module ex_flow_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic        dec_branch,
  input  logic        dec_call,
  input  logic        dec_ret,
  input  logic [3:0]  dec_rs1,
  input  logic [3:0]  dec_rs2,
  input  logic        ex_mem_read,
  input  logic [3:0]  ex_reg_rd,
  input  logic        ex_update_done,
  input  logic        ex_pc_src,
  input  logic        ret_wb,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pc_sel_ex,
  output logic        busy,
  output logic        err,
  output logic [15:0] redirect_cnt
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_WAIT_EX  = 2'd1;
  localparam logic [1:0] S_WAIT_RET = 2'd2;
  localparam logic [1:0] S_ERR      = 2'd3;
  localparam logic [7:0] W_TERM     = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_next;
  logic        r_err;
  logic [15:0] r_redirect_cnt;
  logic        w_lu;
  logic        w_cf;
  logic        w_tc;
  logic        w_redirect;

  assign w_lu = ex_mem_read & (ex_reg_rd != 4'd0) & dec_valid &
                ((ex_reg_rd == dec_rs1) | (ex_reg_rd == dec_rs2));
  assign w_cf = dec_valid & (dec_branch | dec_call | dec_ret);
  assign w_tc = (r_wait_cnt == W_TERM);
  assign w_redirect = (r_state == S_WAIT_EX) & ex_update_done & ex_pc_src;

  assign err          = r_err;
  assign redirect_cnt = r_redirect_cnt;

  // State register, wait counter, sticky error and redirect counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_RUN;
      r_wait_cnt     <= 8'd0;
      r_err          <= 1'b0;
      r_redirect_cnt <= 16'd0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
      if (w_next == S_ERR) begin
        r_err <= 1'b1;
      end
      if (w_redirect && (r_redirect_cnt != 16'hFFFF)) begin
        r_redirect_cnt <= r_redirect_cnt + 16'd1;
      end
    end
  end

  // Next-state decode; a completion event beats the terminal count
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN: begin
        if (w_lu) begin
          w_next = S_RUN;
        end else if (w_cf && dec_ret) begin
          w_next = S_WAIT_RET;
        end else if (w_cf) begin
          w_next = S_WAIT_EX;
        end else begin
          w_next = S_RUN;
        end
      end
      S_WAIT_EX: begin
        if (ex_update_done) begin
          w_next = S_RUN;
        end else if (w_tc) begin
          w_next = S_ERR;
        end else begin
          w_next = S_WAIT_EX;
        end
      end
      S_WAIT_RET: begin
        if (ret_wb) begin
          w_next = S_WAIT_EX;
        end else if (w_tc) begin
          w_next = S_ERR;
        end else begin
          w_next = S_WAIT_RET;
        end
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  // Wait counter restarts on every wait-state entry, counts while waiting
  always_comb begin
    w_wait_next = 8'd0;
    if ((w_next == r_state) && ((r_state == S_WAIT_EX) || (r_state == S_WAIT_RET))) begin
      w_wait_next = r_wait_cnt + 8'd1;
    end else begin
      w_wait_next = 8'd0;
    end
  end

  // Pipeline control outputs from state and current inputs
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pc_sel_ex   = 1'b0;
    busy        = 1'b0;
    if (!rst_n) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      busy = (r_state != S_RUN);
      case (r_state)
        S_RUN: begin
          if (w_lu) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
          end else begin
            pc_stall = 1'b0;
          end
        end
        S_WAIT_EX: begin
          if (ex_update_done) begin
            if (ex_pc_src) begin
              pc_sel_ex   = 1'b1;
              ifid_flush  = 1'b1;
              idex_bubble = 1'b1;
            end else begin
              pc_sel_ex = 1'b0;
            end
          end else begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        default: begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
        end
      endcase
    end
  end

endmodule
